// File: rtl/dm_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Round-robin arbitration is enabled by defining DM_ARB_RR_EN.
package dm_arb_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } owner_e;

endpackage

// File: rtl/dm_arbiter_arb_pick.sv
// Combinational two-way picker for the DM arbiter.
// DM_ARB_RR_EN selects round-robin on ties; otherwise the CPU always wins.
module arb_pick
    import dm_arb_pkg::*;
(
    input  logic   cpu_req_i,
    input  logic   dbg_req_i,
`ifdef DM_ARB_RR_EN
    input  owner_e last_winner_i,
`endif
    output owner_e winner_o
);

    always_comb begin
        winner_o = REQ_CPU;
`ifdef DM_ARB_RR_EN
        if (cpu_req_i && dbg_req_i) begin
            // On a tie the port that did not win last time goes next.
            winner_o = (last_winner_i == REQ_CPU) ? REQ_DBG : REQ_CPU;
        end else if (dbg_req_i) begin
            winner_o = REQ_DBG;
        end
`else
        if (!cpu_req_i && dbg_req_i) begin
            winner_o = REQ_DBG;
        end
`endif
    end

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates the single data memory between the CPU and debug/loader ports.
// Each transfer is IDLE -> ACCESS -> RESP; DM_ARB_RR_EN enables round-robin on ties.
module dm_arbiter #(
    parameter int unsigned DATA_W = dm_arb_pkg::DATA_W,
    parameter int unsigned ADDR_W = dm_arb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic              dm_read,
    output logic              dm_write,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,

    output logic              busy
);

    import dm_arb_pkg::*;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            winner;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              cpu_gnt_q, cpu_gnt_d;
    logic              dbg_gnt_q, dbg_gnt_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dbg_ack_q, dbg_ack_d;
    logic              dm_read_q, dm_read_d;
    logic              dm_write_q, dm_write_d;
    logic              busy_q, busy_d;
`ifdef DM_ARB_RR_EN
    owner_e            last_winner_q, last_winner_d;
`endif

    arb_pick u_arb_pick (
        .cpu_req_i     (cpu_req),
        .dbg_req_i     (dbg_req),
`ifdef DM_ARB_RR_EN
        .last_winner_i (last_winner_q),
`endif
        .winner_o      (winner)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        cpu_gnt_d   = 1'b0;
        dbg_gnt_d   = 1'b0;
        cpu_ack_d   = 1'b0;
        dbg_ack_d   = 1'b0;
        dm_read_d   = 1'b0;
        dm_write_d  = 1'b0;
`ifdef DM_ARB_RR_EN
        last_winner_d = last_winner_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    state_d = ACCESS;
                    owner_d = winner;
                    if (winner == REQ_DBG) begin
                        we_d    = dbg_we;
                        addr_d  = dbg_addr;
                        wdata_d = dbg_wdata;
                    end else begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end
                    // Grant and strobe are registered so they appear in the ACCESS cycle.
                    cpu_gnt_d  = (winner == REQ_CPU);
                    dbg_gnt_d  = (winner == REQ_DBG);
                    dm_read_d  = !we_d;
                    dm_write_d = we_d;
`ifdef DM_ARB_RR_EN
                    last_winner_d = winner;
`endif
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (!we_q) begin
                    if (owner_q == REQ_DBG) dbg_rdata_d = dm_rdata;
                    else                    cpu_rdata_d = dm_rdata;
                end
                cpu_ack_d = (owner_q == REQ_CPU);
                dbg_ack_d = (owner_q == REQ_DBG);
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= REQ_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            cpu_gnt_q   <= 1'b0;
            dbg_gnt_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            dm_read_q   <= 1'b0;
            dm_write_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef DM_ARB_RR_EN
            last_winner_q <= REQ_DBG;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            cpu_gnt_q   <= cpu_gnt_d;
            dbg_gnt_q   <= dbg_gnt_d;
            cpu_ack_q   <= cpu_ack_d;
            dbg_ack_q   <= dbg_ack_d;
            dm_read_q   <= dm_read_d;
            dm_write_q  <= dm_write_d;
            busy_q      <= busy_d;
`ifdef DM_ARB_RR_EN
            last_winner_q <= last_winner_d;
`endif
        end
    end

    assign cpu_gnt   = cpu_gnt_q;
    assign dbg_gnt   = dbg_gnt_q;
    assign cpu_ack   = cpu_ack_q;
    assign dbg_ack   = dbg_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;
    assign dm_read   = dm_read_q;
    assign dm_write  = dm_write_q;
    assign dm_addr   = addr_q;
    assign dm_wdata  = wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed and random checks for dm_arbiter against a 256-byte data-memory model.
// Expected arbitration follows DM_ARB_RR_EN when it is defined for the build.
module tb_dm_arbiter;

    logic       clk;
    logic       rst;
    logic       cpu_req, cpu_we, cpu_gnt, cpu_ack;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       dbg_req, dbg_we, dbg_gnt, dbg_ack;
    logic [7:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic       dm_read, dm_write, busy;
    logic [7:0] dm_addr, dm_wdata, dm_rdata;

    logic [7:0] mem [256] = '{default: 8'h00};

    int   checks   = 0;
    int   failures = 0;
    bit   exp_last = 1'b1;
    logic [7:0] exp_crd = 8'h00;
    logic [7:0] exp_drd = 8'h00;

    dm_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_gnt   (dbg_gnt),
        .dbg_ack   (dbg_ack),
        .dbg_rdata (dbg_rdata),
        .dm_read   (dm_read),
        .dm_write  (dm_write),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dm_rdata = dm_read ? mem[dm_addr] : 8'h00;
    always @(posedge clk) if (dm_write) mem[dm_addr] <= dm_wdata;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_last = 1'b1;
        exp_crd  = 8'h00;
        exp_drd  = 8'h00;
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {dm_read, dm_write}, 0);
        chk("rst_gnt_ack", {cpu_gnt, dbg_gnt, cpu_ack, dbg_ack}, 0);
        chk("rst_dm_addr", dm_addr, 0);
        chk("rst_dm_wdata", dm_wdata, 0);
        chk("rst_rdata", {cpu_rdata, dbg_rdata}, 0);
    endtask

    // One full transfer starting in an IDLE cycle; checks ACCESS, RESP and the following IDLE.
    task automatic xfer(input bit creq, input bit dreq, input bit cwe, input bit dwe,
                        input logic [7:0] ca, input logic [7:0] cd,
                        input logic [7:0] da, input logic [7:0] dd);
        bit         win;
        bit         we;
        logic [7:0] a, d, rd;
        cpu_req = creq; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dreq; dbg_we = dwe; dbg_addr = da; dbg_wdata = dd;
`ifdef DM_ARB_RR_EN
        win = (creq && dreq) ? !exp_last : dreq;
        exp_last = win;
`else
        win = !creq;
`endif
        we = win ? dwe : cwe;
        a  = win ? da : ca;
        d  = win ? dd : cd;
        rd = mem[a];
        tick();
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        chk("acc_gnt", {cpu_gnt, dbg_gnt}, {!win, win});
        chk("acc_strobe", {dm_read, dm_write}, {!we, we});
        chk("acc_addr", dm_addr, a);
        if (we) chk("acc_wdata", dm_wdata, d);
        chk("acc_noack", {cpu_ack, dbg_ack}, 0);
        chk("acc_busy", busy, 1);
        tick();
        chk("resp_ack", {cpu_ack, dbg_ack}, {!win, win});
        chk("resp_excl", {dm_read, dm_write, cpu_gnt, dbg_gnt}, 0);
        if (!we) begin
            if (win) exp_drd = rd;
            else     exp_crd = rd;
        end
        chk("resp_cpu_rdata", cpu_rdata, exp_crd);
        chk("resp_dbg_rdata", dbg_rdata, exp_drd);
        tick();
        chk("idle_quiet", {busy, cpu_ack, dbg_ack, dm_read, dm_write}, 0);
    endtask

    initial begin
        rst = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 8'h00;
        do_reset();

        // CPU write then read back 0x10.
        xfer(1, 0, 1, 0, 8'h10, 8'hA5, 8'h00, 8'h00);
        chk("mem_10", mem[8'h10], 8'hA5);
        xfer(1, 0, 0, 0, 8'h10, 8'h00, 8'h00, 8'h00);
        chk("cpu_rd_10", cpu_rdata, 8'hA5);

        // DBG loads 0x3C at 0xFF, then reads it back; CPU rdata untouched.
        xfer(0, 1, 0, 1, 8'h00, 8'h00, 8'hFF, 8'h3C);
        chk("dbg_wr_keeps_rdata", dbg_rdata, 8'h00);
        xfer(0, 1, 0, 0, 8'h00, 8'h00, 8'hFF, 8'h00);
        chk("dbg_rd_ff", dbg_rdata, 8'h3C);
        chk("cpu_rd_unchanged", cpu_rdata, 8'hA5);

        // DBG request arrives during the CPU's ACCESS cycle.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        tick();
        chk("busy_cpu_gnt", cpu_gnt, 1);
        cpu_req = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'hFF;
        tick();
        chk("busy_cpu_ack", cpu_ack, 1);
        chk("busy_no_dbg_gnt_resp", dbg_gnt, 0);
        tick();
        chk("busy_no_dbg_gnt_idle", {dbg_gnt, busy}, 0);
        tick();
        chk("busy_dbg_gnt", dbg_gnt, 1);
        dbg_req = 1'b0;
        tick();
        chk("busy_dbg_ack", dbg_ack, 1);
        chk("busy_dbg_rdata", dbg_rdata, 8'h3C);
        tick();
`ifdef DM_ARB_RR_EN
        exp_last = 1'b1;
`endif

        // Simultaneous requests held from the first IDLE after reset.
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            bit w;
`ifdef DM_ARB_RR_EN
            w = (i % 2) == 1;
`else
            w = 1'b0;
`endif
            tick();
            chk("tie_gnt", {cpu_gnt, dbg_gnt}, {!w, w});
            if (i == 3) begin
                cpu_req = 1'b0;
                dbg_req = 1'b0;
            end
            tick();
            chk("tie_ack", {cpu_ack, dbg_ack}, {!w, w});
            tick();
        end
        exp_crd = 8'hA5;
`ifdef DM_ARB_RR_EN
        exp_drd  = 8'h3C;
        exp_last = 1'b1;
`endif
        chk("tie_cpu_rdata", cpu_rdata, exp_crd);
        chk("tie_dbg_rdata", dbg_rdata, exp_drd);

        // Reset during a read ACCESS aborts the transfer without an ack.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        tick();
        chk("abort_dm_read", dm_read, 1);
        rst = 1'b1;
        cpu_req = 1'b0;
        tick();
        rst = 1'b0;
        chk("abort_quiet", {busy, dm_read, dm_write, cpu_gnt, dbg_gnt, cpu_ack, dbg_ack}, 0);
        chk("abort_rdata", {cpu_rdata, dbg_rdata}, 0);
        chk("abort_dm_addr", dm_addr, 0);
        exp_last = 1'b1;
        exp_crd  = 8'h00;
        exp_drd  = 8'h00;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_ack", {cpu_ack, dbg_ack}, 0);
        end

        // Random mix of single and simultaneous transfers.
        for (int i = 0; i < 200; i++) begin
            int unsigned r;
            r = $urandom_range(1, 3);
            xfer(r[0], r[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Shares the single 8-bit data memory (DM) between two requesters: the processor datapath (CPU port) and a debug/loader port (DBG port). It accepts a request only when idle, latches the address, write data and direction, and drives DM read/write strobes for exactly one cycle. It then returns a one-cycle acknowledge carrying registered read data. It sits between the datapath's ALU-address/ReadData2 path and the DM, replacing the direct MemRead/MemWrite hookup.

## Interface
- DATA_W, 8, data width of DM words and requester data buses
- ADDR_W, 8, DM address width
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request (level)
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access in progress (ACCESS cycle)
- cpu_ack  out  1  one-cycle completion pulse for CPU
- cpu_rdata  out  DATA_W  last CPU read data; valid when cpu_ack and the access was a read
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_ack, dbg_rdata: same as cpu_* for the debug port
- dm_read  out  1  DM read strobe (MemRead)
- dm_write  out  1  DM write strobe (MemWrite)
- dm_addr  out  ADDR_W  DM address
- dm_wdata  out  DATA_W  DM write data
- dm_rdata  in  DATA_W  DM read data, combinational from dm_addr/dm_read
- busy  out  1  high whenever state != IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req is high, pick a winner and latch its we/addr/wdata and owner id; go to ACCESS. Otherwise stay in IDLE.
- ACCESS: assert owner's gnt and exactly one of dm_read/dm_write, per the latched we. Drive dm_addr/dm_wdata from the latches. On a read, capture dm_rdata into the owner's rdata register at the end of the cycle. Go to RESP.
- RESP: pulse owner's ack. Go to IDLE.
- Requests are ignored in ACCESS and RESP. A req still high in the IDLE cycle after ack is treated as a new transfer. Requesters deassert req in the cycle after ack unless they want another access.
- Payload only has to be valid in the IDLE cycle in which req is sampled.
- dm_read and dm_write are never high together. Both are 0 outside ACCESS.
- dm_addr/dm_wdata hold their latched values between accesses. They are 0 after reset.
- Per-port rdata holds its value until that port's next read completes. A write does not change rdata.
- Address arithmetic: none. Full ADDR_W range is legal, including 0xFF.

## Timing
- Reset values: state IDLE; all gnt, ack, dm_read, dm_write and busy = 0; dm_addr, dm_wdata, cpu_rdata and dbg_rdata = 0; last_winner = DBG.
- Latency: req sampled at edge k; gnt and DM strobe high in cycle k+1; ack high in cycle k+2; earliest next sample at edge k+3.
- Throughput: one transfer per 3 cycles.
- Reset asserted in ACCESS or RESP: at the next edge all outputs return to their reset values. No ack is issued for the aborted transfer, and the requester reissues it. A write strobe already driven in ACCESS is not retracted.

## Configuration
- DM_ARB_RR_EN defined: round-robin arbitration. On simultaneous requests, the port that did not win last gets the grant. last_winner updates on every grant. Reset value DBG means the CPU wins the first tie.
- DM_ARB_RR_EN undefined: fixed priority, CPU always wins ties. The DBG port can starve while the CPU requests continuously. last_winner is not implemented.

## Structure
- Package dm_arb_pkg holds:
  - state encoding: IDLE=2'b00, ACCESS=2'b01, RESP=2'b10
  - owner ids: REQ_CPU=1'b0, REQ_DBG=1'b1
  - default widths DATA_W=8, ADDR_W=8
- One sub-module, arb_pick: combinational two-way picker. Inputs: cpu_req, dbg_req, last_winner. Output: winner id. The RR/fixed selection is made inside it under DM_ARB_RR_EN.

## Test plan
- Single CPU write then read: cpu_we=1, addr 0x10, wdata 0xA5. Expect dm_write=1 only in cycle k+1 and cpu_ack in cycle k+2. Then a read of 0x10 gives cpu_rdata=0xA5 at ack, with dm_read=1 for one cycle.
- Simultaneous requests: both reqs high at the first IDLE after reset. With DM_ARB_RR_EN, order is CPU, DBG, CPU, DBG over 4 transfers. Without it, CPU wins all while it holds req.
- DBG read of addr 0xFF holding 0x3C: dbg_rdata=0x3C at dbg_ack, and cpu_rdata is unchanged.
- Requests during busy: dbg_req rises in the CPU's ACCESS cycle. Expect no dbg_gnt until the CPU's RESP has passed; dbg_gnt then appears 2 cycles after the CPU ack.
- Reset in ACCESS: rst=1 in the cycle where dm_read=1. Expect at the next edge state IDLE, all strobes/gnt/ack=0, rdata=0, and no ack ever issued for the aborted transfer.
- Strobe exclusivity: random 200-transfer mix. Assert dm_read & dm_write is never 1, and exactly one ack per accepted request.
